// File: rtl/cpu_pkg.sv
// Opcode constants and fetch-state encoding shared by the fetch sequencer
// and the control decoder.
package cpu_pkg;

  localparam logic [10:0] OP_HALT     = 11'h7FF;
  localparam logic [5:0]  OP_B_PFX    = 6'b000101;
  localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_PFX = 8'b10110101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_PRESENT,
    ST_WAIT_BR,
    ST_HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [31:0] inst);
    return inst[31:21] == OP_HALT;
  endfunction

  function automatic logic is_branch(input logic [31:0] inst);
    return (inst[31:26] == OP_B_PFX) || (inst[31:24] == OP_CBZ_PFX) ||
           (inst[31:24] == OP_CBNZ_PFX);
  endfunction

endpackage

// File: rtl/cpu_branch_target.sv
// Branch resolution: decides taken and produces the next PC
// (sequential pc+4 or pc + offset*4, both modulo 2^ADDR_W).
module cpu_branch_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_br_uncond,
  input  logic              i_br_zero,
  input  logic              i_br_nonzero,
  input  logic              i_alu_zero,
  input  logic [ADDR_W-1:0] i_br_offset,
  output logic [ADDR_W-1:0] o_seq_pc,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic              w_taken;
  logic [ADDR_W-1:0] w_tgt_pc;

  assign w_taken   = i_br_uncond | (i_br_zero & i_alu_zero) | (i_br_nonzero & ~i_alu_zero);
  assign o_seq_pc  = i_pc + ADDR_W'(4);
  // Word offset is scaled in place; bits shifted past ADDR_W are dropped.
  assign w_tgt_pc  = i_pc + (i_br_offset << 2);
  assign o_next_pc = w_taken ? w_tgt_pc : o_seq_pc;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch sequencer: owns the PC, reads imem, presents words to
// decode over valid/ready, stalls on branches and stops on HALT.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              br_valid,
  input  logic              br_uncond,
  input  logic              br_zero,
  input  logic              br_nonzero,
  input  logic              alu_zero,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              halted,
  output logic [31:0]       inst_count
);

  fetch_state_t      r_state, w_nxt_state;
  logic [ADDR_W-1:0] r_pc, r_inst_pc;
  logic [31:0]       r_inst, r_inst_count;
  logic              r_halted;
  logic [ADDR_W-1:0] w_seq_pc, w_br_pc;

  cpu_branch_target #(.ADDR_W(ADDR_W)) u_br_tgt (
    .i_pc         (r_pc),
    .i_br_uncond  (br_uncond),
    .i_br_zero    (br_zero),
    .i_br_nonzero (br_nonzero),
    .i_alu_zero   (alu_zero),
    .i_br_offset  (br_offset),
    .o_seq_pc     (w_seq_pc),
    .o_next_pc    (w_br_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:    w_nxt_state = ST_REQ;
      ST_REQ:     if (imem_valid) w_nxt_state = ST_PRESENT;
      ST_PRESENT: if (inst_ready) begin
        if (is_halt(r_inst))        w_nxt_state = ST_HALTED;
        else if (is_branch(r_inst)) w_nxt_state = ST_WAIT_BR;
        else                        w_nxt_state = ST_REQ;
      end
      ST_WAIT_BR: if (br_valid) w_nxt_state = ST_REQ;
      ST_HALTED:  w_nxt_state = ST_HALTED;
      default:    w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (r_state)
      ST_REQ:     imem_req   = 1'b1;
      ST_PRESENT: inst_valid = 1'b1;
      default:    ;
    endcase
  end

  // Datapath; branch-class words leave pc alone until resolution arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_inst_pc    <= RESET_PC;
      r_halted     <= 1'b0;
      r_inst_count <= '0;
    end else begin
      case (r_state)
        ST_REQ: if (imem_valid) begin
          r_inst    <= imem_rdata;
          r_inst_pc <= r_pc;
        end
        ST_PRESENT: if (inst_ready) begin
          r_inst_count <= r_inst_count + 32'd1;
          if (is_halt(r_inst))         r_halted <= 1'b1;
          else if (!is_branch(r_inst)) r_pc     <= w_seq_pc;
        end
        ST_WAIT_BR: if (br_valid) r_pc <= w_br_pc;
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign halted     = r_halted;
  assign inst_count = r_inst_count;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: table of fetch/branch vectors against a memory model
// and an accept-order scoreboard, plus HALT, reset and wrap sequences.
module tb_cpu_fetch;

  localparam logic [31:0] W_ADD  = 32'h8B020020;
  localparam logic [31:0] W_B    = 32'h14000000;
  localparam logic [31:0] W_CBZ  = 32'hB4000000;
  localparam logic [31:0] W_CBNZ = 32'hB5000000;
  localparam logic [31:0] W_HALT = 32'hFFE00000;

  typedef struct {
    logic [31:0] word;
    int          mem_lat;
    int          rdy_lat;
    logic        stray;
    logic        brk;
    logic        hlt;
    logic        bu, bz, bnz, az;
    logic [63:0] off;
    logic [63:0] nxt;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_valid = 1'b0, inst_valid, inst_ready = 1'b0, halted;
  logic [63:0] imem_addr, inst_pc, br_offset = '0;
  logic [31:0] imem_rdata = '0, inst, inst_count;
  logic        br_valid = 1'b0, br_uncond = 1'b0, br_zero = 1'b0, br_nonzero = 1'b0, alu_zero = 1'b0;

  wire         w_req, w_ivalid, w_halted;
  wire [7:0]   w_addr, w_inst_pc;
  wire [31:0]  w_inst, w_cnt;

  int          n_vec = 0, n_err = 0;
  int          mem_lat = 0, req_cnt = 0, w_n = 0;
  logic        ovr_en = 1'b0, ovr_valid = 1'b0;
  logic [31:0] ovr_data = '0;
  logic [63:0] model_pc;
  logic [31:0] model_cnt;
  logic [7:0]  w_a [2];
  logic [31:0] mem [logic [63:0]];
  exp_t        exp_q [$];
  vec_t        vt [16];

  always #5 clk = ~clk;

  cpu_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .br_valid(br_valid),
    .br_uncond(br_uncond), .br_zero(br_zero), .br_nonzero(br_nonzero),
    .alu_zero(alu_zero), .br_offset(br_offset), .halted(halted), .inst_count(inst_count)
  );

  // Narrow instance: always-ready memory and decode, straight-line code.
  cpu_fetch #(.ADDR_W(8), .RESET_PC(8'hFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(W_ADD), .imem_valid(w_req), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_valid(w_ivalid), .inst_ready(1'b1), .br_valid(1'b0),
    .br_uncond(1'b0), .br_zero(1'b0), .br_nonzero(1'b0),
    .alu_zero(1'b0), .br_offset(8'h00), .halted(w_halted), .inst_count(w_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Commit this cycle's inputs (memory model + scoreboard), then advance.
  task automatic tick();
    exp_t e;
    if (ovr_en) begin
      imem_valid = ovr_valid;
      imem_rdata = ovr_data;
      req_cnt    = 0;
    end else if (imem_req === 1'b1) begin
      if (req_cnt >= mem_lat) begin
        imem_valid = 1'b1;
        imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : W_ADD;
      end else begin
        imem_valid = 1'b0;
      end
      req_cnt++;
    end else begin
      imem_valid = 1'b0;
      req_cnt    = 0;
    end
    if (inst_valid === 1'b1 && inst_ready) begin
      if (exp_q.size() == 0) fail_now("sb_underflow");
      else begin
        e = exp_q.pop_front();
        chk("sb_inst_pc", inst_pc, e.pc);
        chk("sb_inst", 64'(inst), 64'(e.inst));
      end
    end
    if (w_req === 1'b1 && w_n < 2) begin
      w_a[w_n] = w_addr;
      w_n++;
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    mem[model_pc] = v.word;
    mem_lat       = v.mem_lat;
    inst_ready    = 1'b0;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) fail_now("wait_req");
    chk("imem_addr", imem_addr, model_pc);
    exp_q.push_back('{model_pc, v.word});
    n = 0;
    while (inst_valid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) fail_now("wait_inst_valid");
    if (v.stray) begin
      br_valid = 1'b1; br_uncond = 1'b1; br_offset = 64'h100;
    end
    for (int i = 0; i < v.rdy_lat; i++) begin
      tick();
      chk("hold_inst", 64'(inst), 64'(v.word));
      chk("hold_pc", inst_pc, model_pc);
      chk("hold_addr", imem_addr, model_pc);
      chk("hold_strobes", 64'({imem_req, inst_valid}), 64'b01);
    end
    br_valid = 1'b0; br_uncond = 1'b0;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    model_cnt++;
    chk("inst_count", 64'(inst_count), 64'(model_cnt));
    if (v.hlt) begin
      chk("halted", 64'(halted), 64'd1);
    end else if (v.brk) begin
      tick();
      chk("wait_br_strobes", 64'({imem_req, inst_valid}), 64'b00);
      br_uncond = v.bu; br_zero = v.bz; br_nonzero = v.bnz; alu_zero = v.az;
      br_offset = v.off; br_valid = 1'b1;
      tick();
      br_valid = 1'b0; br_uncond = 1'b0; br_zero = 1'b0; br_nonzero = 1'b0; alu_zero = 1'b0;
    end
    model_pc = v.nxt;
  endtask

  initial begin
    //        word     lat rdy str brk hlt bu bz bnz az  offset                  next pc
    vt[0]  = '{W_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,                  64'h04};
    vt[1]  = '{W_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,                  64'h08};
    vt[2]  = '{W_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,                  64'h0C};
    vt[3]  = '{W_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,                  64'h10};
    vt[4]  = '{W_B,    0, 0, 0, 1, 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h00};
    vt[5]  = '{W_ADD,  3, 2, 1, 0, 0, 0, 0, 0, 0, 64'd0,                  64'h04};
    vt[6]  = '{W_B,    0, 0, 0, 1, 0, 1, 0, 0, 0, 64'd7,                  64'h20};
    vt[7]  = '{W_CBZ,  0, 0, 0, 1, 0, 0, 1, 0, 1, 64'd3,                  64'h2C};
    vt[8]  = '{W_B,    0, 1, 0, 1, 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h20};
    vt[9]  = '{W_CBNZ, 0, 0, 0, 1, 0, 0, 0, 1, 1, 64'd5,                  64'h24};
    vt[10] = '{W_CBZ,  1, 0, 0, 1, 0, 0, 1, 0, 0, 64'd10,                 64'h28};
    vt[11] = '{W_CBNZ, 0, 0, 0, 1, 0, 0, 1, 1, 0, 64'd2,                  64'h30};
    vt[12] = '{W_ADD,  1, 1, 0, 0, 0, 0, 0, 0, 0, 64'd0,                  64'h34};
    vt[13] = '{32'hB6000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0,            64'h38};
    vt[14] = '{32'h17FFFFFF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF2, 64'h00};
    vt[15] = '{W_CBZ,  0, 0, 0, 1, 0, 0, 0, 0, 1, 64'd9,                  64'h04};

    // Reset state
    tick();
    chk("rst_strobes", 64'({imem_req, inst_valid, halted}), 64'b000);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_count", 64'(inst_count), 64'h0);
    rst = 1'b0;
    tick();
    chk("first_req", 64'(imem_req), 64'd1);
    model_pc  = 64'h0;
    model_cnt = 32'd0;

    for (int k = 0; k < 16; k++) run_vec(vt[k]);
    chk("wrap_addr0", 64'(w_a[0]), 64'hFC);
    chk("wrap_addr1", 64'(w_a[1]), 64'h00);
    chk("wrap_not_halted", 64'(w_halted), 64'd0);

    // HALT at 0x8, then a 20-cycle quiet window with stray strobes, then reset.
    rst = 1'b1; tick(); rst = 1'b0;
    model_pc = 64'h0; model_cnt = 32'd0;
    run_vec('{W_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'h04});
    run_vec('{W_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'h08});
    run_vec('{W_HALT, 0, 0, 0, 0, 1, 0, 0, 0, 0, 64'd0, 64'h08});
    for (int i = 0; i < 20; i++) begin
      br_valid = i[0]; br_uncond = 1'b1; inst_ready = 1'b1;
      tick();
      chk("halt_quiet", 64'({imem_req, inst_valid, halted}), 64'b001);
    end
    br_valid = 1'b0; br_uncond = 1'b0; inst_ready = 1'b0;
    chk("halt_pc", imem_addr, 64'h08);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("unhalt", 64'(halted), 64'd0);
    chk("unhalt_pc", imem_addr, 64'h0);
    chk("unhalt_count", 64'(inst_count), 64'd0);

    // Reset during a pending REQ; a response in the IDLE cycle must be dropped.
    mem[64'h0] = W_ADD; mem_lat = 5;
    tick();
    chk("pend_req", 64'(imem_req), 64'd1);
    tick();
    rst = 1'b1; ovr_en = 1'b1; ovr_valid = 1'b1; ovr_data = W_HALT;
    tick();
    rst = 1'b0;
    chk("mid_rst_idle", 64'({imem_req, inst_valid}), 64'b00);
    tick();
    ovr_en = 1'b0; ovr_valid = 1'b0;
    model_pc = 64'h0; model_cnt = 32'd0;
    run_vec('{W_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'h04});
    chk("mid_rst_not_halted", 64'(halted), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
